// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit processor datapath.
package cpu_pkg;
   localparam int WORD_W     = 16;
   localparam int ADDR_W     = 16;
   localparam int DMEM_DEPTH = 1024;

   typedef logic [WORD_W-1:0] word_t;
endpackage : cpu_pkg

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read,
// synchronous clear on reset. Out-of-range addresses read 0 and never write.
module data_mem
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = WORD_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DEPTH      = DMEM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  mem_write,
   output logic [DATA_WIDTH-1:0] read_data
);

   localparam int IDX_W = $clog2(DEPTH);
   // One extra bit so DEPTH itself is representable even when it fills the port.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  in_range_s;
   logic [IDX_W-1:0]      idx_s;

   // Upper address bits only feed the range check; indexing uses the low bits.
   assign in_range_s = ({1'b0, address} < DEPTH_LIMIT);
   assign idx_s      = address[IDX_W-1:0];

   // Storage update: reset clears every word and wins over a coincident write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (mem_write && in_range_s) begin
         mem_r[idx_s] <= write_data;
      end
   end

   // Read mux: current contents only, no bypass of an in-flight write.
   always_comb begin
      read_data = {DATA_WIDTH{1'b0}};
      if (in_range_s) begin
         read_data = mem_r[idx_s];
      end else begin
         read_data = {DATA_WIDTH{1'b0}};
      end
   end

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus queues expected read values,
// a negedge monitor pops and compares them against read_data.
module tb_data_mem;
   import cpu_pkg::*;

   logic  clk;
   logic  rst;
   logic  [ADDR_W-1:0] address;
   word_t write_data;
   logic  mem_write;
   word_t read_data;

   typedef struct {
      word_t exp;
      string name;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   data_mem dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .write_data (write_data),
      .mem_write  (mem_write),
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle just after the rising edge; optionally queue the value
   // read_data must show during that cycle.
   task automatic step(input logic [15:0] a, input bit we, input logic [15:0] wd,
                       input bit r, input bit chk, input logic [15:0] exp,
                       input string name);
      exp_t e;
      @(posedge clk);
      #1;
      address    = a;
      mem_write  = we;
      write_data = wd;
      rst        = r;
      if (chk) begin
         e.exp  = exp;
         e.name = name;
         sb_q.push_back(e);
      end
   endtask

   // Monitor: compare at the falling edge, away from the capturing edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (read_data !== e.exp) begin
            errors++;
            $display("FAIL %s: read_data=%h required=%h (address=%h)",
                     e.name, read_data, e.exp, address);
         end
      end
   end

   initial begin
      rst        = 1'b1;
      address    = 16'h0000;
      write_data = 16'h0000;
      mem_write  = 1'b0;

      // Reset pulse, then sweep
      step(16'd0,    1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, "rst_pulse");
      step(16'd0,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rst_a0");
      step(16'd200,  1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rst_a200");
      step(16'd1023, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rst_a1023");

      // Write A5A5 at 0: old value during the write cycle, new after the edge
      step(16'd0,    1'b1, 16'hA5A5, 1'b0, 1'b1, 16'h0000, "wr0_same_cycle");
      step(16'd0,    1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, "wr0_read");

      // Top word
      step(16'd1023, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000, "top_same_cycle");
      step(16'd1023, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, "top_read");
      step(16'd0,    1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, "top_keeps_a0");

      // Out-of-range write: ignored, reads 0, no aliasing onto low bits
      step(16'd1024, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, "oor_during");
      step(16'd1024, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "oor_read");
      step(16'd0,    1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, "oor_no_alias_a0");
      step(16'h83FF, 1'b1, 16'h7777, 1'b0, 1'b1, 16'h0000, "oor_hi_during");
      step(16'd1023, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, "oor_hi_no_alias");

      // Back-to-back writes to address 5
      step(16'd5,    1'b1, 16'h1111, 1'b0, 1'b1, 16'h0000, "seq_0");
      step(16'd5,    1'b1, 16'h2222, 1'b0, 1'b1, 16'h1111, "seq_1");
      step(16'd5,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, "seq_2");

      // Reset coincident with a write: write dropped, array cleared
      step(16'd7,    1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0000, "rstwr_during");
      step(16'd7,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rstwr_a7");
      step(16'd1023, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rstwr_a1023");
      step(16'd0,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rstwr_a0");
      step(16'd5,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, "rstwr_a5");

      // First write after reset is accepted
      step(16'd7,    1'b1, 16'h0042, 1'b0, 1'b1, 16'h0000, "post_rst_during");
      step(16'd7,    1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042, "post_rst_read");

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4; i++) begin
         if (sb_q.size() == 0) break;
         @(posedge clk);
      end
      @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d required=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_data_mem
